hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the RV32I 5-stage core. It generates the enable and flush controls for the PC, IF/ID and ID/EX registers. It runs a post-reset fill sequence, load-use stalls, taken-branch flushes and an ECALL/EBREAK drain-and-halt sequence. It sits beside `cpu_top`'s datapath: it reads decoded fields from ID and EX and drives the pipeline-register control pins.

## Interface
Parameters:
- BOOT_CYCLES, 2, number of cycles after reset release during which PC is held and the pipeline is flushed; legal range 1..15.
- DRAIN_CYCLES, 3, number of bubble cycles used to retire in-flight instructions (EX, MEM, WB) before halting; legal range 1..7.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 field of the IF/ID instruction.
- id_rs2  in  5  rs2 field of the IF/ID instruction.
- id_uses_rs1  in  1  IF/ID instruction reads rs1.
- id_uses_rs2  in  1  IF/ID instruction reads rs2.
- id_halt  in  1  IF/ID instruction is ECALL/EBREAK.
- ex_rd  in  5  destination register of the ID/EX instruction.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle.
- resume  in  1  leave the halted state.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads NOP (takes priority over if_id_en).
- id_ex_flush  out  1  ID/EX loads a bubble (all control bits zero).
- halted  out  1  core is halted.
- stall_count  out  16  count of load-use stall cycles, saturating.

## Operation
- States: BOOT, RUN, DRAIN, HALT. A 4-bit counter `cnt` is shared by BOOT and DRAIN.
- Reset asserted: state=BOOT, cnt=0, stall_count=0.
- BOOT:
  - Outputs: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1.
  - cnt increments each cycle. The state moves to RUN on the edge where cnt==BOOT_CYCLES-1.
- RUN: outputs are combinational, evaluated in this priority order:
  1. Branch, when ex_branch_taken=1:
     - pc_en=1, if_id_flush=1, id_ex_flush=1. The state stays RUN.
     - The load-use check and id_halt are ignored, because the ID instruction is on the wrong path.
  2. Load-use, when ex_mem_read=1, ex_rd!=0, and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)):
     - pc_en=0, if_id_en=0, if_id_flush=0, id_ex_flush=1.
     - stall_count increments unless it is 16'hFFFF.
  3. Halt, when id_halt=1:
     - pc_en=0, if_id_en=0, id_ex_flush=1.
     - Next state is DRAIN, with cnt loaded to 0.
  4. Otherwise: pc_en=1, if_id_en=1, if_id_flush=0, id_ex_flush=0.
- DRAIN:
  - Outputs: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_flush=1. The halt instruction stays held in IF/ID.
  - ex_branch_taken is ignored, because only bubbles are in EX.
  - cnt increments. The state moves to HALT on the edge where cnt==DRAIN_CYCLES-1.
- HALT:
  - halted=1. Outputs as in DRAIN.
  - resume=1 gives, for one cycle: pc_en=1, if_id_en=1, id_ex_flush=1. Next state is RUN.
  - Effect of resume: IF/ID takes the instruction at halt+4, the halt is dropped without executing, and PC advances to halt+8.
- halted is registered, equal to (state==HALT). All other control outputs are combinational from state and inputs.
- resume is ignored outside HALT.

## Timing
- Reset values, while reset is low: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1, halted=0, stall_count=0.
- Reset asserted mid-operation forces BOOT immediately (asynchronous). Any DRAIN or HALT in progress is abandoned.
- First PC advance: pc_en=1 in the cycle BOOT_CYCLES clocks after reset deasserts. With the default, that is the 3rd clock edge.
- Load-use stall: exactly 1 cycle per hazard. On the next cycle the load has moved to MEM and ex_mem_read reflects the bubble.
- Taken branch: single-cycle flush of 2 instructions. No state change.
- Halt latency: id_halt seen at cycle T gives halted=1 from cycle T+DRAIN_CYCLES+1.
- stall_count updates on the clock edge ending the stall cycle.

## Test plan
- Boot: release reset at t0 with BOOT_CYCLES=2 -> pc_en=0 for the first 2 cycles and =1 on the 3rd; both flushes are 1 during BOOT; halted=0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, and stall_count goes 0 to 1. The same inputs with ex_rd=0 -> no stall.
- Branch over hazard and halt: ex_branch_taken=1 together with a load-use match and id_halt=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1; state stays RUN; stall_count is unchanged.
- Halt and resume: id_halt=1 in RUN -> 3 DRAIN cycles, then halted=1 and held for 10 cycles. resume=1 -> one cycle of pc_en=1, if_id_en=1, id_ex_flush=1; halted=0 the next cycle.
- Saturation: force 65537 load-use cycles -> stall_count holds at 16'hFFFF.
- Async reset during DRAIN: pull reset low mid-drain -> outputs take their reset values without waiting for a clock edge; after release, the full BOOT sequence repeats.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX enables and flushes for boot, load-use, branch and halt.
// Latency: controls are combinational from state and ID/EX fields; halted and stall_count are registered.
// Backpressure: a load-use hazard holds PC and IF/ID for one cycle and injects a bubble into ID/EX.
module hazard_ctrl #(
    parameter int BOOT_CYCLES  = 2,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_halt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        resume,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;
    logic       stall;
    logic       go_drain;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

    // Default is the "hold everything, bubble ID/EX" pattern shared by DRAIN and HALT.
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b1;
        stall       = 1'b0;
        go_drain    = 1'b0;
        case (state)
            ST_BOOT: begin
                if_id_flush = 1'b1;
            end
            ST_RUN: begin
                if (ex_branch_taken) begin
                    // ID holds a wrong-path instruction, so its hazard and halt are moot.
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    if_id_flush = 1'b1;
                end else if (load_use) begin
                    stall = 1'b1;
                end else if (id_halt) begin
                    go_drain = 1'b1;
                end else begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    id_ex_flush = 1'b0;
                end
            end
            ST_DRAIN: begin
            end
            ST_HALT: begin
                // Resume overwrites the held halt with halt+4 and never lets it reach EX.
                if (resume) begin
                    pc_en    = 1'b1;
                    if_id_en = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_BOOT;
            cnt         <= 4'd0;
            halted      <= 1'b0;
            stall_count <= 16'd0;
        end else begin
            case (state)
                ST_BOOT: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == BOOT_LAST) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stall && (stall_count != 16'hFFFF)) begin
                        stall_count <= stall_count + 16'd1;
                    end
                    if (go_drain) begin
                        state <= ST_DRAIN;
                        cnt   <= 4'd0;
                    end
                end
                ST_DRAIN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == DRAIN_LAST) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state  <= ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule
